// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: samples a multiplexed 7-segment bus, filters each digit
// for stability, decodes it back to BCD and presents whole frames on a
// valid/ready interface.
module seg7_scan_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [NUM_DIGITS-1:0]   err_out
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic {
        COLLECT,
        HOLD
    } state_t;

    state_t                  state;
    logic [6:0]              s_seg;
    logic [6:0]              p_seg;
    logic [NUM_DIGITS-1:0]   s_sel;
    logic [NUM_DIGITS-1:0]   p_sel;
    logic [CW-1:0]           cnt;
    logic [CW-1:0]           cnt_next;
    logic                    captured;
    logic                    changed;
    logic                    qualify;
    logic                    capture;
    logic [NUM_DIGITS-1:0]   mask;
    logic [4*NUM_DIGITS-1:0] slot_bcd;
    logic [NUM_DIGITS-1:0]   slot_err;
    logic [3:0]              dec_bcd;
    logic                    dec_err;

    // Register the raw bus once, and keep the previous registered sample for comparison
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_seg <= '0;
            s_sel <= '0;
            p_seg <= '0;
            p_sel <= '0;
        end else begin
            s_seg <= seg;
            s_sel <= dig_sel;
            p_seg <= s_seg;
            p_sel <= s_sel;
        end
    end

    // Next stability count; qualification looks at the count being loaded this edge
    // so a dwell held from edge 0 is taken at edge STABLE_CYCLES
    always_comb begin
        changed  = ({s_seg, s_sel} != {p_seg, p_sel});
        cnt_next = cnt;
        if (changed) begin
            cnt_next = CNT_ONE;
        end else if (cnt != CNT_MAX) begin
            cnt_next = cnt + CNT_ONE;
        end
        qualify = (cnt_next == CNT_MAX) && $onehot(s_sel) && (changed || !captured);
        capture = qualify && (state == COLLECT);
    end

    // Decode the registered segment pattern back to BCD
    always_comb begin
        dec_err = 1'b0;
        case (s_seg)
            7'b1111110: dec_bcd = 4'd0;
            7'b0110000: dec_bcd = 4'd1;
            7'b1101101: dec_bcd = 4'd2;
            7'b1111001: dec_bcd = 4'd3;
            7'b0110011: dec_bcd = 4'd4;
            7'b1011011: dec_bcd = 4'd5;
            7'b1011111: dec_bcd = 4'd6;
            7'b1110000: dec_bcd = 4'd7;
            7'b1111111: dec_bcd = 4'd8;
            7'b1111011: dec_bcd = 4'd9;
            default: begin
                dec_bcd = 4'hF;
                dec_err = 1'b1;
            end
        endcase
    end

    // Stability counter and one-capture-per-dwell flag; a qualifying dwell marks
    // itself taken even when the FSM drops it, so it is not picked up late
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            captured <= 1'b0;
        end else begin
            cnt <= cnt_next;
            if (qualify) begin
                captured <= 1'b1;
            end else if (changed) begin
                captured <= 1'b0;
            end
        end
    end

    // Frame FSM: fill working slots while collecting, publish a full mask one edge
    // later, then hold the frame until the consumer accepts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= COLLECT;
            mask      <= '0;
            slot_bcd  <= '0;
            slot_err  <= '0;
            out_valid <= 1'b0;
            bcd_out   <= '0;
            err_out   <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (&mask) begin
                        bcd_out   <= slot_bcd;
                        err_out   <= slot_err;
                        out_valid <= 1'b1;
                        mask      <= '0;
                        state     <= HOLD;
                    end else if (capture) begin
                        mask <= mask | s_sel;
                        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                            if (s_sel[i]) begin
                                slot_bcd[4*i +: 4] <= dec_bcd;
                                slot_err[i]        <= dec_err;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Scoreboard bench for seg7_scan_reader: stimulus pushes expected frames,
// a monitor pops and compares them as out_valid rises.
module tb_seg7_scan_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [6:0]  seg;
    logic [3:0]  dig_sel;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] bcd_out;
    logic [3:0]  err_out;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [15:0] bcd;
        logic [3:0]  err;
    } frame_t;

    frame_t exp_q[$];
    frame_t cur;
    logic   mon_prev = 1'b0;

    always #5 clk = ~clk;

    seg7_scan_reader #(
        .NUM_DIGITS   (4),
        .STABLE_CYCLES(3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .seg      (seg),
        .dig_sel  (dig_sel),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .bcd_out  (bcd_out),
        .err_out  (err_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] pat(input logic [3:0] d);
        case (d)
            4'd0: pat = 7'h7E;
            4'd1: pat = 7'h30;
            4'd2: pat = 7'h6D;
            4'd3: pat = 7'h79;
            4'd4: pat = 7'h33;
            4'd5: pat = 7'h5B;
            4'd6: pat = 7'h5F;
            4'd7: pat = 7'h70;
            4'd8: pat = 7'h7F;
            4'd9: pat = 7'h7B;
            default: pat = 7'h00;
        endcase
    endfunction

    task automatic hold(input logic [6:0] s, input logic [3:0] sel, input int n);
        seg     = s;
        dig_sel = sel;
        repeat (n) @(negedge clk);
    endtask

    task automatic dig(input int i, input logic [6:0] s);
        logic [3:0] sel;
        sel = 4'b0001 << i;
        hold(s, sel, 5);
    endtask

    task automatic idle(input int n);
        hold(7'h00, 4'h0, n);
    endtask

    task automatic scan_frame(input logic [15:0] digits);
        for (int i = 0; i < 4; i++) dig(i, pat(digits[4*i +: 4]));
    endtask

    task automatic wait_valid(input string name, input int budget);
        int k;
        k = 0;
        while (!out_valid && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, {31'd0, out_valid}, 32'd1);
    endtask

    task automatic handshake(input string name);
        check({name, "_bcd_held"}, {16'd0, bcd_out}, {16'd0, cur.bcd});
        check({name, "_err_held"}, {28'd0, err_out}, {28'd0, cur.err});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // Monitor: one sample per cycle, 1 time unit after the rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_prev && out_ready) begin
                check("drop_after_accept", {31'd0, out_valid}, 32'd0);
            end else if (!mon_prev && out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", {31'd0, out_valid}, 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    check("frame_bcd", {16'd0, bcd_out}, {16'd0, cur.bcd});
                    check("frame_err", {28'd0, err_out}, {28'd0, cur.err});
                end
            end
            mon_prev = out_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        out_ready = 1'b0;
        seg       = 7'h00;
        dig_sel   = 4'h0;
        #1 rst_n  = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seg     = 7'($urandom);
            dig_sel = 4'($urandom);
        end
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_bcd", {16'd0, bcd_out}, 32'd0);
        check("rst_err", {28'd0, err_out}, 32'd0);
        seg     = 7'h00;
        dig_sel = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(6);
        check("post_rst_valid", {31'd0, out_valid}, 32'd0);
        check("post_rst_bcd", {16'd0, bcd_out}, 32'd0);
        check("post_rst_err", {28'd0, err_out}, 32'd0);

        // Clean frame, held under back-pressure before acceptance
        exp_q.push_back('{bcd: 16'h3210, err: 4'h0});
        scan_frame(16'h3210);
        idle(3);
        wait_valid("clean_valid", 10);
        idle(5);
        handshake("clean");
        idle(2);

        // Glitch of 2 cycles must not be taken; the following 4-cycle dwell is
        exp_q.push_back('{bcd: 16'h3510, err: 4'h0});
        dig(0, pat(4'd0));
        dig(1, pat(4'd1));
        hold(7'h7F, 4'b0100, 2);
        hold(pat(4'd5), 4'b0100, 4);
        dig(3, pat(4'd3));
        idle(3);
        wait_valid("filter5_valid", 10);
        handshake("filter5");
        idle(2);

        // Exactly STABLE_CYCLES of dwell is enough
        exp_q.push_back('{bcd: 16'h3810, err: 4'h0});
        dig(0, pat(4'd0));
        dig(1, pat(4'd1));
        hold(7'h7F, 4'b0100, 3);
        dig(3, pat(4'd3));
        idle(3);
        wait_valid("filter8_valid", 10);
        handshake("filter8");
        idle(2);

        // Illegal patterns and illegal selects
        exp_q.push_back('{bcd: 16'hF2F0, err: 4'b1010});
        dig(0, pat(4'd0));
        dig(1, 7'h00);
        dig(2, pat(4'd2));
        hold(7'h7F, 4'b0110, 10);
        hold(7'h49, 4'b0000, 10);
        dig(3, 7'h49);
        idle(3);
        wait_valid("illegal_valid", 10);
        handshake("illegal");
        idle(2);

        // Back-pressure: a scan during HOLD is dropped
        exp_q.push_back('{bcd: 16'h9876, err: 4'h0});
        scan_frame(16'h9876);
        idle(3);
        wait_valid("bp_valid", 10);
        scan_frame(16'h7654);
        idle(3);
        check("bp_still_valid", {31'd0, out_valid}, 32'd1);
        handshake("bp");
        idle(20);
        check("bp_no_stale_frame", {31'd0, out_valid}, 32'd0);
        exp_q.push_back('{bcd: 16'h7654, err: 4'h0});
        dig(0, pat(4'd4));
        dig(1, pat(4'd5));
        dig(2, pat(4'd6));
        idle(10);
        check("partial_no_valid", {31'd0, out_valid}, 32'd0);
        dig(3, pat(4'd7));
        idle(3);
        wait_valid("fresh_valid", 10);
        handshake("fresh");
        idle(2);

        // Reset mid-frame discards partial captures
        dig(0, pat(4'd1));
        dig(1, pat(4'd2));
        dig(2, pat(4'd3));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        dig(3, pat(4'd4));
        idle(10);
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_bcd", {16'd0, bcd_out}, 32'd0);
        check("midrst_err", {28'd0, err_out}, 32'd0);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
